// File: rtl/fp_int_norm.sv
// Purpose: converts a two's-complement accumulator with a shared exponent into IEEE-754 binary16 (round-to-nearest-even, saturating, flush-to-zero).
// Latency: out_valid rises 3+k cycles after acceptance, k = leading-zero shift count of |acc_in| (0..31, 0 for zero input).
// Backpressure: one result in flight; in_ready only in IDLE, result held in HOLD until out_ready, outputs keep last value afterwards.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, acc_in[31:0], exp_in[4:0]   : input handshake, value = acc_in * 2^(exp_in-25)
//   out_valid/out_ready, fp_out[15:0], ovf, unf    : output handshake, binary16 result and saturate/flush flags
module fp_int_norm (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] acc_in,
    input  logic [4:0]  exp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] fp_out,
    output logic        ovf,
    output logic        unf
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [31:0]        r_acc;
    logic [4:0]         r_exp;
    logic               r_sign;
    logic [31:0]        r_mag;
    logic [4:0]         r_k;
    logic [15:0]        r_fp;
    logic               r_ovf;
    logic               r_unf;
    logic               r_out_valid;

    logic               w_norm_done;
    logic [9:0]         w_mant;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic [10:0]        w_mant_sum;
    logic signed [7:0]  w_exp_pre;
    logic signed [7:0]  w_exp_post;
    logic [15:0]        w_fp;
    logic               w_ovf;
    logic               w_unf;

    // Normalisation stops once the hidden bit sits in bit 31, or immediately for zero.
    assign w_norm_done = r_mag[31] || (r_mag == 32'd0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ABS;
                end
            end
            ABS:   w_next_state = NORM;
            NORM: begin
                if (w_norm_done) begin
                    w_next_state = ROUND;
                end
            end
            ROUND: w_next_state = HOLD;
            HOLD: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Rounding and exception encoding from the normalised magnitude
    // ------------------------------------------------------------------
    always_comb begin
        w_mant     = r_mag[30:21];
        w_guard    = r_mag[20];
        w_sticky   = |r_mag[19:0];
        w_round_up = w_guard & (w_sticky | w_mant[0]);
        w_mant_sum = {1'b0, w_mant} + {10'd0, w_round_up};
        // mag[31] carries weight 2^(exp+6-k) relative to the unbiased value, plus bias 15 -> exp+21-k.
        w_exp_pre  = 8'sd21 + $signed({3'b000, r_exp}) - $signed({3'b000, r_k});
        // A carry out of 0x3FF leaves w_mant_sum[9:0] = 0 and bumps the exponent.
        w_exp_post = w_exp_pre + $signed({7'd0, w_mant_sum[10]});

        w_fp  = {r_sign, w_exp_post[4:0], w_mant_sum[9:0]};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_mag == 32'd0) begin
            w_fp = 16'h0000;
        end else if (w_exp_post >= 8'sd31) begin
            w_fp  = {r_sign, 5'h1F, 10'h000};
            w_ovf = 1'b1;
        end else if (w_exp_post <= 8'sd0) begin
            w_fp  = {r_sign, 15'h0000};
            w_unf = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= 32'd0;
            r_exp       <= 5'd0;
            r_sign      <= 1'b0;
            r_mag       <= 32'd0;
            r_k         <= 5'd0;
            r_fp        <= 16'h0000;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc <= acc_in;
                        r_exp <= exp_in;
                    end
                end
                ABS: begin
                    r_sign <= r_acc[31];
                    // Negating 0x80000000 wraps back to 0x80000000, the correct unsigned magnitude.
                    r_mag  <= r_acc[31] ? (~r_acc + 32'd1) : r_acc;
                    r_k    <= 5'd0;
                end
                NORM: begin
                    if (!w_norm_done) begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_k   <= r_k + 5'd1;
                    end
                end
                ROUND: begin
                    r_fp        <= w_fp;
                    r_ovf       <= w_ovf;
                    r_unf       <= w_unf;
                    r_out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign fp_out    = r_fp;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule

// File: tb/tb_fp_int_norm.sv
// Purpose: self-checking bench for fp_int_norm; driver pushes expected results into a scoreboard, monitor pops on each new out_valid.
// Latency: expected latency (3+k) is carried with each scoreboard entry and checked against the cycle counter.
// Backpressure: out_ready is normally 1; one directed phase holds it low to exercise HOLD.
module tb_fp_int_norm;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] acc_in;
    logic [4:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] fp_out;
    logic        ovf;
    logic        unf;

    fp_int_norm dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_in    (acc_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_out    (fp_out),
        .ovf       (ovf),
        .unf       (unf)
    );

    typedef struct {
        logic [15:0] fp;
        logic        ovf;
        logic        unf;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_v   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Wait (bounded) for in_ready, present one transaction, record the acceptance cycle.
    task automatic send(input logic [31:0] a, input logic [4:0] e,
                        input logic [15:0] fp, input logic o, input logic u,
                        input int lat, input bit push);
        exp_t x;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            acc_in   = a;
            exp_in   = e;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (push) begin
                x.fp = fp; x.ovf = o; x.unf = u; x.lat = lat; x.acc_cyc = cyc;
                sb.push_back(x);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < budget) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        chk("drain_timeout", (sb.size() != 0 || !in_ready) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Monitor: compare on each rising out_valid.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {16'd0, fp_out}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("fp_out", {16'd0, fp_out}, {16'd0, e.fp});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    chk("unf", {31'd0, unf}, {31'd0, e.unf});
                    chk("latency", cyc - e.acc_cyc, e.lat);
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0d required=done", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        acc_in    = 32'd0;
        exp_in    = 5'd0;
        out_ready = 1'b1;
        #23;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fp_out", {16'd0, fp_out}, 32'd0);
        chk("rst_flags", {30'd0, ovf, unf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: acc, exp, fp, ovf, unf, latency
        send(32'h0000_0400,  5'd15, 16'h3C00, 1'b0, 1'b0, 24, 1'b1);
        send(32'hFFFF_F400,  5'd15, 16'hC200, 1'b0, 1'b0, 23, 1'b1);
        send(32'h8000_0000,  5'd0,  16'hD400, 1'b0, 1'b0,  3, 1'b1); // -2^31 * 2^-25 = -64
        send(32'h0000_0801,  5'd15, 16'h4000, 1'b0, 1'b0, 23, 1'b1); // tie, stays even
        send(32'h0000_0803,  5'd15, 16'h4002, 1'b0, 1'b0, 23, 1'b1); // tie, rounds up to even
        send(32'h0000_0FFF,  5'd15, 16'h4400, 1'b0, 1'b0, 23, 1'b1); // carry into exponent
        send(32'h7FFF_FFFF,  5'd31, 16'h7C00, 1'b1, 1'b0,  4, 1'b1);
        send(32'h0000_0001,  5'd0,  16'h0000, 1'b0, 1'b1, 34, 1'b1);
        send(32'h0000_0000,  5'd15, 16'h0000, 1'b0, 1'b0,  3, 1'b1);
        send(32'h0000_0001,  5'd24, 16'h3800, 1'b0, 1'b0, 34, 1'b1); // 0.5
        wait_idle(400);

        // Backpressure: hold out_ready low for 10 cycles in HOLD, pulse in_valid meanwhile.
        out_ready = 1'b0;
        send(32'h0000_0803, 5'd15, 16'h4002, 1'b0, 1'b0, 23, 1'b1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n = n + 1;
            end
        end
        chk("hold_reached", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                acc_in   = 32'h0000_0400;
                exp_in   = 5'd15;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("hold_fp_stable", {16'd0, fp_out}, 32'h4002);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_fp_kept", {16'd0, fp_out}, 32'h4002);
        repeat (40) @(posedge clk);
        #1;

        // Reset mid-NORM: long-shift input, abort after a few cycles.
        send(32'h0000_0001, 5'd0, 16'h0000, 1'b0, 1'b1, 34, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_fp_out", {16'd0, fp_out}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        #10;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send(32'hFFFF_F400, 5'd15, 16'hC200, 1'b0, 1'b0, 23, 1'b1);
        wait_idle(400);
        repeat (40) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
